// File: rtl/channel_scanner.sv
// Round-robin select generator for a 4-to-1 channel selector: steps through
// the eligible channels on a dwell timer or on manual step requests.
module channel_scanner #(
  parameter int DWELL = 4
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEn,
  input  logic [3:0] iMask,
  input  logic       iManual,
  input  logic       iStep,
  output logic       oS1,
  output logic       oS0,
  output logic       oValid,
  output logic       oWrap
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [15:0] LastCnt = 16'(DWELL - 1);

  state_t      state_q;
  logic [1:0]  sel_q;
  logic [15:0] cnt_q;
  logic        wrap_q;
  logic        manual_q;
  logic [1:0]  nextSel;
  logic [1:0]  firstSel;
  logic        advWrap;

  // Searches cur+1, cur+2, cur+3 and falls back to cur itself.
  function automatic logic [1:0] nextElig(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] idx;
    logic [1:0] res;
    res = cur;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  function automatic logic [1:0] lowestElig(input logic [3:0] mask);
    logic [1:0] res;
    res = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) res = 2'(k);
    end
    return res;
  endfunction

  assign nextSel  = nextElig(sel_q, iMask);
  assign firstSel = lowestElig(iMask);
  assign advWrap  = (nextSel <= sel_q);

  // A single-channel mask advances onto itself, which still counts as a wrap.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 16'd0;
      wrap_q   <= 1'b0;
      manual_q <= 1'b0;
    end else if (!iEn || (iMask == 4'd0)) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 16'd0;
      wrap_q   <= 1'b0;
      manual_q <= iManual;
    end else begin
      manual_q <= iManual;
      case (state_q)
        IDLE: begin
          state_q <= SCAN;
          sel_q   <= firstSel;
          cnt_q   <= 16'd0;
          wrap_q  <= 1'b0;
        end
        default: begin
          if (!iMask[sel_q]) begin
            sel_q  <= nextSel;
            cnt_q  <= 16'd0;
            wrap_q <= advWrap;
          end else if (iManual != manual_q) begin
            cnt_q  <= 16'd0;
            wrap_q <= 1'b0;
          end else if (!iManual) begin
            if (cnt_q == LastCnt) begin
              sel_q  <= nextSel;
              cnt_q  <= 16'd0;
              wrap_q <= advWrap;
            end else begin
              cnt_q  <= cnt_q + 16'd1;
              wrap_q <= 1'b0;
            end
          end else begin
            cnt_q <= 16'd0;
            if (iStep) begin
              sel_q  <= nextSel;
              wrap_q <= advWrap;
            end else begin
              wrap_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign oS1    = sel_q[1];
  assign oS0    = sel_q[0];
  assign oValid = (state_q == SCAN) & iMask[sel_q];
  assign oWrap  = wrap_q;

endmodule

// File: tb/tb_channel_scanner.sv
// Directed-vector bench for channel_scanner: a cycle-by-cycle table for the
// default dwell plus hand sequences for combinational validity and DWELL=1.
module tb_channel_scanner;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] mask;
    logic       man;
    logic       step;
    logic [1:0] sel;
    logic       valid;
    logic       wrap;
  } vec_t;

  logic       iClk = 1'b0;
  logic       iRst, iEn, iManual, iStep;
  logic [3:0] iMask;
  logic       oS1, oS0, oValid, oWrap;
  logic       d1S1, d1S0, d1Valid, d1Wrap;

  int   numVectors = 0;
  int   numMiscompares = 0;
  vec_t vecs[$];

  always #5 iClk = ~iClk;

  channel_scanner #(.DWELL(4)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iMask(iMask), .iManual(iManual),
    .iStep(iStep), .oS1(oS1), .oS0(oS0), .oValid(oValid), .oWrap(oWrap)
  );

  channel_scanner #(.DWELL(1)) dut1 (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iMask(iMask), .iManual(iManual),
    .iStep(iStep), .oS1(d1S1), .oS0(d1S0), .oValid(d1Valid), .oWrap(d1Wrap)
  );

  task automatic addVec(input int n, input logic r, input logic e, input logic [3:0] m,
                        input logic man, input logic st, input logic [1:0] s,
                        input logic v, input logic w);
    vec_t t;
    t.rst = r; t.en = e; t.mask = m; t.man = man; t.step = st;
    t.sel = s; t.valid = v; t.wrap = w;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  // Inputs change 1 time unit after the rising edge and hold through the next one.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] m,
                               input logic man, input logic st);
    iRst = r; iEn = e; iMask = m; iManual = man; iStep = st;
    @(posedge iClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    numVectors++;
    if (act !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got {sel,valid,wrap}=%b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    iRst = 1'b1; iEn = 1'b1; iMask = 4'hF; iManual = 1'b0; iStep = 1'b0;

    // Reset, then automatic full scan with DWELL=4
    addVec(2, 1, 1, 4'hF, 0, 0, 2'd0, 0, 0);
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd0, 1, 0);
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd1, 1, 0);
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd2, 1, 0);
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd3, 1, 0);
    addVec(1, 0, 1, 4'hF, 0, 0, 2'd0, 1, 1);
    addVec(3, 0, 1, 4'hF, 0, 0, 2'd0, 1, 0);
    // Sparse mask 1010 entered from IDLE
    addVec(1, 0, 0, 4'hF, 0, 0, 2'd0, 0, 0);
    addVec(4, 0, 1, 4'hA, 0, 0, 2'd1, 1, 0);
    addVec(4, 0, 1, 4'hA, 0, 0, 2'd3, 1, 0);
    addVec(1, 0, 1, 4'hA, 0, 0, 2'd1, 1, 1);
    addVec(3, 0, 1, 4'hA, 0, 0, 2'd1, 1, 0);
    // Mask 0100 removes channel 1 (forced advance), then single-channel wraps
    addVec(4, 0, 1, 4'h4, 0, 0, 2'd2, 1, 0);
    addVec(1, 0, 1, 4'h4, 0, 0, 2'd2, 1, 1);
    addVec(3, 0, 1, 4'h4, 0, 0, 2'd2, 1, 0);
    addVec(1, 0, 1, 4'h4, 0, 0, 2'd2, 1, 1);
    // Manual stepping
    addVec(1, 0, 1, 4'hF, 1, 0, 2'd2, 1, 0);
    addVec(1, 0, 1, 4'hF, 1, 1, 2'd3, 1, 0);
    addVec(1, 0, 1, 4'hF, 1, 1, 2'd0, 1, 1);
    addVec(1, 0, 1, 4'hF, 1, 1, 2'd1, 1, 0);
    addVec(1, 0, 1, 4'hF, 1, 0, 2'd1, 1, 0);
    addVec(1, 0, 1, 4'hF, 1, 1, 2'd2, 1, 0);
    addVec(1, 0, 1, 4'hF, 1, 0, 2'd2, 1, 0);
    addVec(1, 0, 1, 4'hF, 1, 1, 2'd3, 1, 0);
    addVec(1, 0, 1, 4'hF, 1, 1, 2'd0, 1, 1);
    addVec(1, 0, 1, 4'hF, 1, 1, 2'd1, 1, 0);
    addVec(3, 0, 1, 4'hF, 1, 0, 2'd1, 1, 0);
    // Back to automatic (counter restarts), then drop channel 2 at counter=1
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd1, 1, 0);
    addVec(2, 0, 1, 4'hF, 0, 0, 2'd2, 1, 0);
    addVec(4, 0, 1, 4'hB, 0, 0, 2'd3, 1, 0);
    addVec(1, 0, 1, 4'hB, 0, 0, 2'd0, 1, 1);
    addVec(1, 0, 1, 4'h0, 0, 0, 2'd0, 0, 0);
    // Enable drop and reset mid-dwell
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd0, 1, 0);
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd1, 1, 0);
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd2, 1, 0);
    addVec(2, 0, 1, 4'hF, 0, 0, 2'd3, 1, 0);
    addVec(1, 0, 0, 4'hF, 0, 0, 2'd0, 0, 0);
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd0, 1, 0);
    addVec(2, 0, 1, 4'hF, 0, 0, 2'd1, 1, 0);
    addVec(1, 1, 1, 4'hF, 0, 0, 2'd0, 0, 0);
    addVec(4, 0, 1, 4'hF, 0, 0, 2'd0, 1, 0);
    addVec(1, 0, 1, 4'hF, 0, 0, 2'd1, 1, 0);
    // Empty mask keeps the block idle even when enabled
    addVec(2, 0, 1, 4'h0, 0, 0, 2'd0, 0, 0);
    // Entering in manual mode, then a forced advance with no step
    addVec(1, 0, 1, 4'hF, 1, 0, 2'd0, 1, 0);
    addVec(2, 0, 1, 4'hE, 1, 0, 2'd1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mask, vecs[i].man, vecs[i].step);
      checkOutput($sformatf("vec%0d", i), {oS1, oS0, oValid, oWrap},
                  {vecs[i].sel, vecs[i].valid, vecs[i].wrap});
    end

    // oValid follows the mask within the cycle, before sel moves
    iMask = 4'hC;
    #1;
    checkOutput("combValid", {oS1, oS0, oValid, oWrap}, {2'd1, 1'b0, 1'b0});
    applyStimulus(0, 1, 4'hC, 1, 0);
    checkOutput("forcedManual", {oS1, oS0, oValid, oWrap}, {2'd2, 1'b1, 1'b0});

    // DWELL=1: advance every cycle, back-to-back wraps on a single channel
    applyStimulus(1, 1, 4'hF, 0, 0);
    checkOutput("d1Reset", {d1S1, d1S0, d1Valid, d1Wrap}, {2'd0, 1'b0, 1'b0});
    applyStimulus(0, 1, 4'hF, 0, 0);
    checkOutput("d1Entry", {d1S1, d1S0, d1Valid, d1Wrap}, {2'd0, 1'b1, 1'b0});
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 1, 4'hF, 0, 0);
      checkOutput($sformatf("d1Step%0d", k), {d1S1, d1S0, d1Valid, d1Wrap},
                  {2'(k), 1'b1, (k == 4) ? 1'b1 : 1'b0});
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 4'h1, 0, 0);
      checkOutput($sformatf("d1Single%0d", k), {d1S1, d1S0, d1Valid, d1Wrap},
                  {2'd0, 1'b1, 1'b1});
    end

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
